// File: rtl/sample_pio_edge_irq_if.sv
// Avalon-MM slave bus for the edge-capturing input PIO.
// The master drives the select/write side and the slave returns registered read data.
interface sample_pio_edge_irq_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sample_pio_edge_irq.sv
// Input PIO with a synchroniser, per-bit edge capture, an interrupt mask and an IRQ output.
// It lets the CPU take an interrupt on external strobes instead of polling them.
module sample_pio_edge_irq #(
   parameter int unsigned      WIDTH       = 1,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      EDGE_TYPE   = 0,
   parameter int unsigned      IRQ_TYPE    = 1,
   parameter int unsigned      BIT_CLEAR   = 1,
   parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sample_pio_edge_irq_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EC   = 2'd3;

   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] detect;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] ec_nxt;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;
   logic             wr_mask;
   logic             wr_ec;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign data_in = in_port;
      end else begin : g_sync
         // Stage 0 sits in the low WIDTH bits; the oldest stage is at the top.
         logic [SYNC_STAGES*WIDTH-1:0] sync;
         logic [SYNC_STAGES*WIDTH-1:0] sync_nxt;

         always_comb begin
            sync_nxt              = sync << WIDTH;
            sync_nxt[WIDTH-1:0]   = in_port;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync <= '0;
            else          sync <= sync_nxt;
         end

         assign data_in = sync[SYNC_STAGES*WIDTH-1 -: WIDTH];
      end
   endgenerate

   always_comb begin
      detect = data_in ^ prev;
      case (EDGE_TYPE)
         0:       detect = data_in & ~prev;
         1:       detect = ~data_in & prev;
         default: detect = data_in ^ prev;
      endcase
   end

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign wr_mask      = wr_en && (bus.address == ADDR_MASK);
   assign wr_ec        = wr_en && (bus.address == ADDR_EC);
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   // A new edge always wins over a clear issued in the same cycle.
   always_comb begin
      ec_nxt = edgecapture | detect;
      if (wr_ec) begin
         if (BIT_CLEAR != 0) ec_nxt = (edgecapture & ~wdata) | detect;
         else                ec_nxt = detect;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev        <= '0;
         edgecapture <= '0;
         irqmask     <= RESET_MASK;
      end else begin
         prev        <= data_in;
         edgecapture <= ec_nxt;
         if (wr_mask) irqmask <= wdata;
      end
   end

   // Direction (address 1) is input-only and always reads back as zero.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = data_in;
         ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
         ADDR_EC:   rd_mux[WIDTH-1:0] = edgecapture;
         default:   rd_mux = '0;
      endcase
   end

   // The read register is loaded every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.readdata <= '0;
      else          bus.readdata <= rd_mux;
   end

   assign irq = (IRQ_TYPE == 0) ? |(data_in & irqmask) : |(edgecapture & irqmask);
endmodule

// File: tb/tb_sample_pio_edge_irq.sv
// Scoreboard bench for two PIO configurations sharing one stimulus stream.
// The reference model works from per-bit edge/set/clear rules and an input delay line.
module tb_sample_pio_edge_irq;
   localparam int W = 4;
   // dut0: rising, edge irq, bit clear, sync 2.  dut1: any edge, level irq, clear-all, sync 1.
   localparam int S0 = 2, E0 = 0, I0 = 1, B0 = 1;
   localparam int S1 = 1, E1 = 2, I1 = 0, B1 = 0;
   localparam logic [W-1:0] M0 = 4'h0;
   localparam logic [W-1:0] M1 = 4'h3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [W-1:0] in_port = '0;
   logic         irq0, irq1;
   int           n_checks = 0;
   int           n_err = 0;

   sample_pio_edge_irq_if bus0();
   sample_pio_edge_irq_if bus1();

   sample_pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(S0), .EDGE_TYPE(E0), .IRQ_TYPE(I0),
                         .BIT_CLEAR(B0), .RESET_MASK(M0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));

   sample_pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(S1), .EDGE_TYPE(E1), .IRQ_TYPE(I1),
                         .BIT_CLEAR(B1), .RESET_MASK(M1)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [W-1:0] hist [4];          // hist[n]: in_port sampled n+1 edges ago
   logic [W-1:0] m_prev [2];
   logic [W-1:0] m_ec   [2];
   logic [W-1:0] m_mask [2];
   logic [31:0]  q0 [$];
   logic [31:0]  q1 [$];

   function automatic logic [W-1:0] f_din(int d);
      int s = (d == 0) ? S0 : S1;
      return (s == 0) ? in_port : hist[s-1];
   endfunction

   function automatic logic [W-1:0] f_det(int d);
      logic [W-1:0] r = '0;
      logic [W-1:0] v = f_din(d);
      int et = (d == 0) ? E0 : E1;
      for (int b = 0; b < W; b++) begin
         if (et == 0)      r[b] = v[b] && !m_prev[d][b];
         else if (et == 1) r[b] = !v[b] && m_prev[d][b];
         else              r[b] = v[b] != m_prev[d][b];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] f_ec_next(int d);
      logic [W-1:0] r = '0;
      logic [W-1:0] det = f_det(d);
      logic wr3 = bus0.chipselect && !bus0.write_n && bus0.address == 2'd3;
      int bc = (d == 0) ? B0 : B1;
      for (int b = 0; b < W; b++) begin
         if (det[b])                                          r[b] = 1'b1;
         else if (wr3 && (bc == 0 || bus0.writedata[b] == 1'b1)) r[b] = 1'b0;
         else                                                 r[b] = m_ec[d][b];
      end
      return r;
   endfunction

   function automatic logic [31:0] f_rd(int d);
      case (bus0.address)
         2'd0:    return {28'd0, f_din(d)};
         2'd2:    return {28'd0, m_mask[d]};
         2'd3:    return {28'd0, m_ec[d]};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic f_irq(int d);
      int it = (d == 0) ? I0 : I1;
      return (it == 0) ? |(f_din(d) & m_mask[d]) : |(m_ec[d] & m_mask[d]);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) hist[i] <= '0;
         for (int k = 0; k < 2; k++) begin
            m_prev[k] <= '0;
            m_ec[k]   <= '0;
         end
         m_mask[0] <= M0;
         m_mask[1] <= M1;
         q0.delete();
         q1.delete();
      end else begin
         if (bus0.chipselect && bus0.write_n) begin
            q0.push_back(f_rd(0));
            q1.push_back(f_rd(1));
         end
         for (int k = 0; k < 2; k++) begin
            m_ec[k]   <= f_ec_next(k);
            m_prev[k] <= f_din(k);
            if (bus0.chipselect && !bus0.write_n && bus0.address == 2'd2)
               m_mask[k] <= bus0.writedata[W-1:0];
         end
         hist[0] <= in_port;
         for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (q0.size() > 0) chk("rd0", bus0.readdata, q0.pop_front());
         if (q1.size() > 0) chk("rd1", bus1.readdata, q1.pop_front());
         chk("irq0", {31'd0, irq0}, {31'd0, f_irq(0)});
         chk("irq1", {31'd0, irq1}, {31'd0, f_irq(1)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
      bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = wd;
      bus1.chipselect = cs; bus1.write_n = wn; bus1.address = a; bus1.writedata = wd;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd);
      drive(1'b1, 1'b0, a, wd);
      tick();
      drive(1'b0, 1'b1, 2'd0, 32'd0);
   endtask

   task automatic rd(input logic [1:0] a);
      drive(1'b1, 1'b1, a, 32'd0);
      tick();
      drive(1'b0, 1'b1, 2'd0, 32'd0);
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b1, 2'd0, 32'd0);
      repeat (n) tick();
   endtask

   initial begin
      drive(1'b0, 1'b1, 2'd0, 32'd0);
      #1 reset_n = 1'b0;
      #20;
      chk("rst_rd0", bus0.readdata, 32'd0);
      chk("rst_rd1", bus1.readdata, 32'd0);
      chk("rst_irq0", {31'd0, irq0}, 32'd0);
      tick();
      reset_n = 1'b1;

      // reset values, then mask write/readback
      for (int a = 0; a < 4; a++) rd(a[1:0]);
      wr(2'd2, 32'hF);
      rd(2'd2);

      // single rising edge, read, clear
      in_port = 4'h1;
      idle(2);
      rd(2'd3);
      wr(2'd3, 32'h1);
      idle(2);

      // set on bit 1 collides with a clear of bits 0 and 1
      in_port = 4'h3;
      idle(2);
      wr(2'd3, 32'h3);
      rd(2'd3);

      // masked capture, then unmask
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h0);
      in_port = 4'h7;
      idle(3);
      rd(2'd3);
      wr(2'd2, 32'h4);
      idle(2);

      // 3-cycle pulse on bit 3, clear-all via a zero write, twice
      for (int r = 0; r < 2; r++) begin
         in_port = 4'hF;
         idle(3);
         in_port = 4'h7;
         idle(3);
         rd(2'd3);
         wr(2'd3, 32'h0);
         rd(2'd3);
         wr(2'd3, 32'hF);
      end

      // reset mid-operation with bit 0 held high
      in_port = 4'h0;
      idle(3);
      wr(2'd2, 32'hF);
      wr(2'd3, 32'hF);
      in_port = 4'h5;
      idle(3);
      in_port = 4'h1;
      idle(1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_irq0", {31'd0, irq0}, 32'd0);
      chk("mid_rst_irq1", {31'd0, irq1}, 32'd0);
      chk("mid_rst_rd0", bus0.readdata, 32'd0);
      tick();
      reset_n = 1'b1;
      idle(4);
      rd(2'd3);
      wr(2'd3, 32'hF);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) in_port = W'($urandom);
         case ($urandom_range(3))
            0, 1: idle(1);
            2:    rd(2'($urandom));
            default: wr(2'($urandom), $urandom);
         endcase
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
